// File: rtl/shot_resolver.sv
// Resolves each shot against the five placed ships: hit/miss/sunk/duplicate/error,
// with per-ship damage masks, a 100-cell shot history and a sticky all-sunk flag.
module shot_resolver #(
    parameter int NUM_SHIPS   = 5,
    parameter int BOARD_CELLS = 100
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic [7*NUM_SHIPS-1:0] ship_pos,
    input  logic [NUM_SHIPS-1:0]   ship_vert,
    input  logic                   shot_valid,
    input  logic [6:0]             shot_pos,
    output logic                   shot_ready,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic                   result_hit,
    output logic                   result_sunk,
    output logic [2:0]             result_ship,
    output logic                   result_dup,
    output logic                   result_err,
    output logic                   all_sunk
);

    // Handshakes: a shot transfers on a clock edge where shot_valid & shot_ready
    // (only in IDLE); a result transfers where result_valid & result_ready, and
    // the result fields hold steady from result_valid rising until that edge.

    typedef enum logic [2:0] {IDLE, SCAN, UPDATE, ERR, RESP} state_t;

    localparam int TOTAL_CELLS = 17;

    state_t             state;
    state_t             state_next;
    logic [6:0]         shot_reg;
    logic               dup_reg;
    logic [2:0]         k;
    logic               found;
    logic [2:0]         found_ship;
    logic [2:0]         found_seg;
    logic [4:0]         mask [NUM_SHIPS];
    logic [BOARD_CELLS-1:0] board;
    logic [4:0]         hit_cnt;

    function automatic logic [2:0] len_of(input int idx);
        case (idx)
            0:       return 3'd5;
            1:       return 3'd4;
            2:       return 3'd3;
            3:       return 3'd3;
            default: return 3'd2;
        endcase
    endfunction

    // Column by repeated threshold compare; only meaningful for 0..99.
    function automatic logic [3:0] col_of(input logic [6:0] v);
        logic [6:0] r;
        r = v;
        for (int i = 1; i <= 9; i++) begin
            if (v >= 7'(10 * i)) r = v - 7'(10 * i);
        end
        return r[3:0];
    endfunction

    // Per-cycle match of the latched shot against ship k.
    logic [6:0]        anchor;
    logic              vert;
    logic [2:0]        len;
    logic signed [7:0] d;
    logic              match;
    logic [2:0]        seg;

    always_comb begin
        anchor = 7'd0;
        vert   = 1'b0;
        len    = 3'd0;
        match  = 1'b0;
        seg    = 3'd0;
        for (int i = 0; i < NUM_SHIPS; i++) begin
            if (k == 3'(i)) begin
                anchor = ship_pos[7*i +: 7];
                vert   = ship_vert[i];
                len    = len_of(i);
            end
        end
        d = $signed({1'b0, shot_reg} - {1'b0, anchor});
        if (!vert) begin
            if (!d[7] && (d[6:0] < {4'd0, len}) && (col_of(shot_reg) >= col_of(anchor))) begin
                match = 1'b1;
                seg   = d[2:0];
            end
        end else begin
            for (int j = 0; j < 5; j++) begin
                if ((3'(j) < len) && (d == 8'(10 * j))) begin
                    match = 1'b1;
                    seg   = 3'(j);
                end
            end
        end
    end

    logic [4:0] seg_bit;
    logic [4:0] mask_sel;
    logic [4:0] full_sel;

    always_comb begin
        seg_bit  = 5'd1 << found_seg;
        mask_sel = 5'd0;
        full_sel = 5'd0;
        for (int i = 0; i < NUM_SHIPS; i++) begin
            if (found_ship == 3'(i)) begin
                mask_sel = mask[i];
                full_sel = 5'((6'd1 << len_of(i)) - 6'd1);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (shot_valid) begin
                    state_next = (shot_pos >= 7'(BOARD_CELLS)) ? ERR : SCAN;
                end
            end
            SCAN:    if (k == 3'(NUM_SHIPS - 1)) state_next = UPDATE;
            UPDATE:  state_next = RESP;
            ERR:     state_next = RESP;
            RESP:    if (result_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear) state <= IDLE;
        else              state <= state_next;
    end

    assign shot_ready   = (state == IDLE);
    assign result_valid = (state == RESP);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            shot_reg    <= 7'd0;
            dup_reg     <= 1'b0;
            k           <= 3'd0;
            found       <= 1'b0;
            found_ship  <= 3'd7;
            found_seg   <= 3'd0;
            board       <= '0;
            hit_cnt     <= 5'd0;
            all_sunk    <= 1'b0;
            result_hit  <= 1'b0;
            result_sunk <= 1'b0;
            result_ship <= 3'd7;
            result_dup  <= 1'b0;
            result_err  <= 1'b0;
            for (int i = 0; i < NUM_SHIPS; i++) mask[i] <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (shot_valid) begin
                        shot_reg   <= shot_pos;
                        dup_reg    <= (shot_pos < 7'(BOARD_CELLS)) && board[shot_pos];
                        k          <= 3'd0;
                        found      <= 1'b0;
                        found_ship <= 3'd7;
                        found_seg  <= 3'd0;
                    end
                end
                SCAN: begin
                    // Lower ship index wins on overlap: first match sticks.
                    if (!found && match) begin
                        found      <= 1'b1;
                        found_ship <= k;
                        found_seg  <= seg;
                    end
                    k <= k + 3'd1;
                end
                UPDATE: begin
                    result_hit  <= found;
                    result_ship <= found ? found_ship : 3'd7;
                    result_dup  <= dup_reg;
                    result_err  <= 1'b0;
                    result_sunk <= 1'b0;
                    if (!dup_reg) begin
                        board[shot_reg] <= 1'b1;
                        if (found) begin
                            for (int i = 0; i < NUM_SHIPS; i++) begin
                                if (found_ship == 3'(i)) mask[i] <= mask[i] | seg_bit;
                            end
                            if ((mask_sel | seg_bit) == full_sel) result_sunk <= 1'b1;
                            hit_cnt <= hit_cnt + 5'd1;
                            if (hit_cnt == 5'(TOTAL_CELLS - 1)) all_sunk <= 1'b1;
                        end
                    end
                end
                ERR: begin
                    result_hit  <= 1'b0;
                    result_sunk <= 1'b0;
                    result_ship <= 3'd7;
                    result_dup  <= 1'b0;
                    result_err  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shot_resolver.sv
// Directed bench for shot_resolver: hand-computed results, latency, dup/err,
// all-sunk, backpressure, clear mid-scan and reset during a pending result.
module tb_shot_resolver;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic [34:0] ship_pos;
    logic [4:0]  ship_vert;
    logic        shot_valid;
    logic [6:0]  shot_pos;
    logic        shot_ready;
    logic        result_valid;
    logic        result_ready;
    logic        result_hit;
    logic        result_sunk;
    logic [2:0]  result_ship;
    logic        result_dup;
    logic        result_err;
    logic        all_sunk;

    int n_checks = 0;
    int n_fail   = 0;
    int lat;
    logic       r_hit, r_sunk, r_dup, r_err;
    logic [2:0] r_ship;

    int sweep_pos  [12] = '{0, 1, 3, 4, 77, 78, 79, 55, 65, 75, 88, 89};
    int sweep_ship [12] = '{0, 0, 0, 0, 2, 2, 2, 3, 3, 3, 4, 4};
    int sweep_sunk [12] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 1};

    shot_resolver dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .ship_pos     (ship_pos),
        .ship_vert    (ship_vert),
        .shot_valid   (shot_valid),
        .shot_pos     (shot_pos),
        .shot_ready   (shot_ready),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_hit   (result_hit),
        .result_sunk  (result_sunk),
        .result_ship  (result_ship),
        .result_dup   (result_dup),
        .result_err   (result_err),
        .all_sunk     (all_sunk)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [6:0] pos);
        @(negedge clk);
        shot_valid = 1'b1;
        shot_pos   = pos;
        @(posedge clk);
        #1 shot_valid = 1'b0;
    endtask

    // Latency counts the acceptance edge as cycle 1.
    task automatic wait_result(output int l);
        l = 1;
        while (!result_valid && l < 40) begin
            @(posedge clk);
            #1 l++;
        end
        chk("result_timeout", 32'(result_valid), 32'd1);
        r_hit  = result_hit;
        r_sunk = result_sunk;
        r_ship = result_ship;
        r_dup  = result_dup;
        r_err  = result_err;
    endtask

    task automatic take();
        result_ready = 1'b1;
        @(posedge clk);
        #1 result_ready = 1'b0;
    endtask

    task automatic fire(input logic [6:0] pos);
        accept(pos);
        wait_result(lat);
        take();
    endtask

    initial begin : main
        logic       stable;
        logic       saw_valid;
        logic [6:0] snap;

        rst          = 1'b1;
        clear        = 1'b0;
        shot_valid   = 1'b0;
        shot_pos     = 7'd0;
        result_ready = 1'b0;
        ship_pos     = {7'd88, 7'd55, 7'd78, 7'd20, 7'd0};
        ship_vert    = 5'b01010;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("reset_result_valid", 32'(result_valid), 32'd0);
        chk("reset_shot_ready", 32'(shot_ready), 32'd1);
        chk("reset_result_ship", 32'(result_ship), 32'd7);
        chk("reset_hit", 32'(result_hit), 32'd0);
        chk("reset_all_sunk", 32'(all_sunk), 32'd0);

        fire(7'd2);
        chk("s2_latency", 32'(lat), 32'd7);
        chk("s2_hit", 32'(r_hit), 32'd1);
        chk("s2_ship", 32'(r_ship), 32'd0);
        chk("s2_sunk", 32'(r_sunk), 32'd0);
        chk("s2_dup", 32'(r_dup), 32'd0);
        chk("s2_err", 32'(r_err), 32'd0);

        fire(7'd30);
        chk("s30_hit", 32'(r_hit), 32'd1);
        chk("s30_ship", 32'(r_ship), 32'd1);
        chk("s30_sunk", 32'(r_sunk), 32'd0);
        fire(7'd40);
        chk("s40_ship", 32'(r_ship), 32'd1);
        chk("s40_sunk", 32'(r_sunk), 32'd0);
        fire(7'd50);
        chk("s50_ship", 32'(r_ship), 32'd1);
        chk("s50_sunk", 32'(r_sunk), 32'd0);
        fire(7'd20);
        chk("s20_ship", 32'(r_ship), 32'd1);
        chk("s20_sunk", 32'(r_sunk), 32'd1);

        fire(7'd40);
        chk("dup40_hit", 32'(r_hit), 32'd1);
        chk("dup40_ship", 32'(r_ship), 32'd1);
        chk("dup40_dup", 32'(r_dup), 32'd1);
        chk("dup40_sunk", 32'(r_sunk), 32'd0);

        fire(7'd80);
        chk("s80_hit", 32'(r_hit), 32'd0);
        chk("s80_ship", 32'(r_ship), 32'd7);
        chk("s80_dup", 32'(r_dup), 32'd0);
        fire(7'd80);
        chk("dup80_dup", 32'(r_dup), 32'd1);
        chk("dup80_hit", 32'(r_hit), 32'd0);

        fire(7'd105);
        chk("err_latency", 32'(lat), 32'd2);
        chk("err_err", 32'(r_err), 32'd1);
        chk("err_hit", 32'(r_hit), 32'd0);
        chk("err_ship", 32'(r_ship), 32'd7);

        // Move ship 2 to 77 and finish off every remaining cell.
        ship_pos = {7'd88, 7'd55, 7'd77, 7'd20, 7'd0};
        for (int i = 0; i < 12; i++) begin
            fire(7'(sweep_pos[i]));
            chk($sformatf("sweep%0d_hit", sweep_pos[i]), 32'(r_hit), 32'd1);
            chk($sformatf("sweep%0d_ship", sweep_pos[i]), 32'(r_ship), 32'(sweep_ship[i]));
            chk($sformatf("sweep%0d_sunk", sweep_pos[i]), 32'(r_sunk), 32'(sweep_sunk[i]));
            chk($sformatf("sweep%0d_all_sunk", sweep_pos[i]), 32'(all_sunk), 32'(i == 11));
        end

        fire(7'd0);
        chk("post_dup0_dup", 32'(r_dup), 32'd1);
        chk("post_dup0_sunk", 32'(r_sunk), 32'd0);
        chk("post_all_sunk_sticky", 32'(all_sunk), 32'd1);

        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        chk("clear_all_sunk", 32'(all_sunk), 32'd0);
        chk("clear_result_ship", 32'(result_ship), 32'd7);
        fire(7'd0);
        chk("clear_s0_dup", 32'(r_dup), 32'd0);
        chk("clear_s0_hit", 32'(r_hit), 32'd1);

        // Backpressure: fields frozen and new shots refused while result pending.
        accept(7'd1);
        wait_result(lat);
        snap = {r_hit, r_sunk, r_ship, r_dup, r_err};
        shot_valid = 1'b1;
        shot_pos   = 7'd3;
        stable     = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if ({result_hit, result_sunk, result_ship, result_dup, result_err} !== snap ||
                shot_ready !== 1'b0 || result_valid !== 1'b1) stable = 1'b0;
        end
        shot_valid = 1'b0;
        chk("hold_stable", 32'(stable), 32'd1);
        chk("hold_s1_ship", 32'(snap[4:2]), 32'd0);
        take();
        fire(7'd3);
        chk("ignored_s3_dup", 32'(r_dup), 32'd0);
        chk("ignored_s3_hit", 32'(r_hit), 32'd1);

        // Clear during SCAN drops the shot.
        accept(7'd4);
        @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        chk("midscan_shot_ready", 32'(shot_ready), 32'd1);
        saw_valid = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (result_valid !== 1'b0) saw_valid = 1'b1;
        end
        chk("midscan_no_result", 32'(saw_valid), 32'd0);
        fire(7'd1);
        chk("midscan_board_clear", 32'(r_dup), 32'd0);
        fire(7'd4);
        chk("midscan_s4_dup", 32'(r_dup), 32'd0);

        // Reset while a result is waiting.
        accept(7'd9);
        wait_result(lat);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_resp_valid", 32'(result_valid), 32'd0);
        chk("rst_resp_ship", 32'(result_ship), 32'd7);
        chk("rst_resp_ready", 32'(shot_ready), 32'd1);
        fire(7'd1);
        chk("rst_board_clear", 32'(r_dup), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
